// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and default operand geometry for the serial arithmetic units
package arith_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 4;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/sub_digit.sv
// sub_digit: combinational DIGIT-bit subtract slice, x - y - bin -> diff with borrow out
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout
);
  assign {bout, diff} = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
endmodule

// File: rtl/sub_serial.sv
// sub_serial: digit-serial subtractor {bo,d} = a - b - bi over WIDTH/DIGIT cycles
// Optional signed overflow output ovf is built when SUB_SERIAL_OVF_EN is defined.
module sub_serial import arith_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef SUB_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       ra, rb, acc, nd;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [DIGIT-1:0]       dd;
  logic                   br, bout, a_msb, b_msb, last;
  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x(ra[DIGIT-1:0]), .y(rb[DIGIT-1:0]), .bin(br), .diff(dd), .bout(bout)
  );
  // result digits enter at the top and migrate down, so after N steps acc is LSB-aligned
  assign cat   = {dd, acc};
  assign nd    = cat[WIDTH+DIGIT-1:DIGIT];
  assign last  = cnt == CW'(N - 1);
  assign ready = state == IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      d     <= '0;
      bo    <= 1'b0;
      done  <= 1'b0;
      br    <= 1'b0;
      cnt   <= '0;
`ifdef SUB_SERIAL_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          ra    <= a;
          rb    <= b;
          br    <= bi;
          a_msb <= a[WIDTH-1];
          b_msb <= b[WIDTH-1];
          cnt   <= '0;
          state <= RUN;
        end
      end else begin
        ra  <= ra >> DIGIT;
        rb  <= rb >> DIGIT;
        acc <= nd;
        br  <= bout;
        cnt <= cnt + 1'b1;
        if (last) begin
          d     <= nd;
          bo    <= bout;
          done  <= 1'b1;
          state <= IDLE;
`ifdef SUB_SERIAL_OVF_EN
          ovf   <= (a_msb != b_msb) & (nd[WIDTH-1] != a_msb);
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed and random checks of sub_serial (WIDTH=32, DIGIT=4)
module tb_sub_serial;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, bi = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        ready, done, bo;
  logic [31:0] d;
  int          n_cmp = 0, n_bad = 0;
`ifdef SUB_SERIAL_OVF_EN
  logic        ovf;
`endif

  sub_serial dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bi(bi),
    .ready(ready), .done(done), .d(d), .bo(bo)
`ifdef SUB_SERIAL_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // issue one operation and wait (bounded) for done; reports latency and ready-low cycles
  task automatic op(input logic [31:0] aa, input logic [31:0] bb, input logic bbi,
                    output int lat, output int lows);
    @(negedge clk);
    a = aa; b = bb; bi = bbi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    lows = 0;
    while (!done && lat < 40) begin
      if (!ready) lows++;
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, lows;
  logic [32:0] gold;
  logic [31:0] ra, rb;
  logic        rbi;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_d", d, 0);
    check("rst_bo", bo, 0);
    check("rst_done", done, 0);
    check("rst_ready", ready, 1);
`ifdef SUB_SERIAL_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    op(32'h5, 32'h3, 1'b0, lat, lows);
    check("lat_5m3", lat, 9);
    check("lows_5m3", lows, 8);
    check("d_5m3", d, 32'h2);
    check("bo_5m3", bo, 0);
    check("ready_at_done", ready, 1);
`ifdef SUB_SERIAL_OVF_EN
    check("ovf_5m3", ovf, 0);
`endif
    @(negedge clk);
    check("done_pulse", done, 0);

    op(32'h0, 32'h0, 1'b1, lat, lows);
    check("lat_0m0", lat, 9);
    check("d_0m0b", d, 32'hFFFF_FFFF);
    check("bo_0m0b", bo, 1);

    op(32'h8000_0000, 32'h1, 1'b0, lat, lows);
    check("d_minm1", d, 32'h7FFF_FFFF);
    check("bo_minm1", bo, 0);
`ifdef SUB_SERIAL_OVF_EN
    check("ovf_minm1", ovf, 1);
`endif

    op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, lat, lows);
    check("d_mix", d, 32'h7777_7787);
    check("bo_mix", bo, 1);
`ifdef SUB_SERIAL_OVF_EN
    check("ovf_mix", ovf, 0);
`endif

    // start held through RUN with a changing; start also present in the done cycle
    @(negedge clk);
    a = 32'h5; b = 32'h3; bi = 1'b0; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!done) a = a + 32'h100;
    end while (!done && lat < 40);
    check("held_lat", lat, 9);
    check("held_d", d, 32'h2);
    a = 32'h10; b = 32'h1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_ready", ready, 0);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_lat", lat, 9);
    check("b2b_d", d, 32'hF);

    // reset during the 4th RUN cycle aborts the operation
    @(negedge clk);
    a = 32'hFF; b = 32'h1; bi = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_d", d, 0);
    check("abort_bo", bo, 0);
    check("abort_ready", ready, 1);
    lows = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) lows++;
    end
    check("abort_nodone", lows, 0);

    for (int i = 0; i < 10; i++) begin
      ra = $urandom; rb = $urandom; rbi = 1'($urandom);
      gold = {1'b0, ra} - {1'b0, rb} - {32'b0, rbi};
      op(ra, rb, rbi, lat, lows);
      check("rnd_lat", lat, 9);
      check("rnd_res", {bo, d}, gold);
      if (n_bad != 0) break;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
